// File: rtl/valout_frame_checker_pkg.sv
// Shared types and default widths for the valout frame checker and its accumulator.
// summary_t is the frame summary record at the default widths.
package valout_chk_pkg;

   localparam int DEF_DATA_W = 33;
   localparam int DEF_ACC_W  = 40;
   localparam int DEF_LEN_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DEF_ACC_W-1:0]  sum;
      logic [DEF_DATA_W-1:0] xor_sig;
      logic [DEF_LEN_W:0]    count;
      logic                  ovf;
   } summary_t;

endpackage

// File: rtl/valout_frame_checker_if.sv
// Sample stream in, frame summary out; master drives samples and consumes summaries.
interface valout_frame_checker_if
   import valout_chk_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = DEF_LEN_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [DATA_W-1:0] out_xor;
   logic [LEN_W:0]    out_count;
   logic              out_ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_xor, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_xor, out_count, out_ovf
   );
endinterface

// File: rtl/valout_frame_accum.sv
// Frame accumulator registers (sum, xor, count, sticky carry when VALOUT_FRAME_CHECKER_OVF_EN).
// o_*_nxt give the frame value including the sample being accepted this cycle.
module valout_frame_accum
   import valout_chk_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_acc,
   input  logic [DATA_W-1:0] i_data,
   output logic [ACC_W-1:0]  o_sum_nxt,
   output logic [DATA_W-1:0] o_xor_nxt,
   output logic [LEN_W:0]    o_cnt_nxt,
   output logic              o_ovf_nxt
);

   logic [ACC_W-1:0]  r_sum;
   logic [DATA_W-1:0] r_xor;
   logic [LEN_W:0]    r_cnt;
   logic [ACC_W-1:0]  w_data_ext;
   logic [ACC_W-1:0]  w_sum_add;

   assign w_data_ext = ACC_W'(i_data);

`ifdef VALOUT_FRAME_CHECKER_OVF_EN
   logic             r_ovf;
   logic [ACC_W:0]   w_add_wide;

   assign w_add_wide = {1'b0, r_sum} + {1'b0, w_data_ext};
   assign w_sum_add  = w_add_wide[ACC_W-1:0];
   // The first sample of a frame cannot carry, and it restarts the sticky flag.
   assign o_ovf_nxt  = i_load ? 1'b0 : (r_ovf | w_add_wide[ACC_W]);
`else
   assign w_sum_add  = r_sum + w_data_ext;
   assign o_ovf_nxt  = 1'b0;
`endif

   assign o_sum_nxt = i_load ? w_data_ext : w_sum_add;
   assign o_xor_nxt = i_load ? i_data : (r_xor ^ i_data);
   assign o_cnt_nxt = i_load ? (LEN_W+1)'(1) : (r_cnt + (LEN_W+1)'(1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sum <= '0;
         r_xor <= '0;
         r_cnt <= '0;
`ifdef VALOUT_FRAME_CHECKER_OVF_EN
         r_ovf <= 1'b0;
`endif
      end else if (i_clear) begin
         r_sum <= '0;
         r_xor <= '0;
         r_cnt <= '0;
`ifdef VALOUT_FRAME_CHECKER_OVF_EN
         r_ovf <= 1'b0;
`endif
      end else if (i_load || i_acc) begin
         r_sum <= o_sum_nxt;
         r_xor <= o_xor_nxt;
         r_cnt <= o_cnt_nxt;
`ifdef VALOUT_FRAME_CHECKER_OVF_EN
         r_ovf <= o_ovf_nxt;
`endif
      end
   end

endmodule

// File: rtl/valout_frame_checker.sv
// Frames io_valOut samples into cfg_len-sample summaries (sum, xor, count); summary valid one cycle after the last sample,
// held until consumed while in_ready is low. Optional sticky carry flag under VALOUT_FRAME_CHECKER_OVF_EN.
module valout_frame_checker
   import valout_chk_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [LEN_W-1:0]       cfg_len,
   input  logic                   abort,
   output logic                   busy,
   valout_frame_checker_if.slave  io
);

   state_t            r_state;
   logic [LEN_W:0]    r_len_q;
   logic              r_out_valid;
   logic [ACC_W-1:0]  r_out_sum;
   logic [DATA_W-1:0] r_out_xor;
   logic [LEN_W:0]    r_out_count;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_first;
   logic              w_last;
   logic [LEN_W:0]    w_len_cfg;
   logic [ACC_W-1:0]  w_sum_nxt;
   logic [DATA_W-1:0] w_xor_nxt;
   logic [LEN_W:0]    w_cnt_nxt;
   logic              w_ovf_nxt;

   // A zero length encodes the full 2^LEN_W frame.
   assign w_len_cfg  = (cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cfg_len};
   assign w_in_ready = (r_state != HOLD) && !abort;
   assign w_accept   = io.in_valid && w_in_ready;
   assign w_first    = w_accept && (r_state == IDLE);
   assign w_last     = w_accept && (w_cnt_nxt == (w_first ? w_len_cfg : r_len_q));

   valout_frame_accum #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .LEN_W  (LEN_W)
   ) u_accum (
      .clock     (clock),
      .reset     (reset),
      .i_clear   (abort),
      .i_load    (w_first),
      .i_acc     (w_accept && (r_state == ACCUM)),
      .i_data    (io.in_data),
      .o_sum_nxt (w_sum_nxt),
      .o_xor_nxt (w_xor_nxt),
      .o_cnt_nxt (w_cnt_nxt),
      .o_ovf_nxt (w_ovf_nxt)
   );

`ifdef VALOUT_FRAME_CHECKER_OVF_EN
   logic r_out_ovf;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_out_ovf <= 1'b0;
      end else if (!abort && w_last) begin
         r_out_ovf <= w_ovf_nxt;
      end
   end

   assign io.out_ovf = r_out_ovf;
`else
   assign io.out_ovf = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_len_q     <= '0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_xor   <= '0;
         r_out_count <= '0;
      end else if (abort) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
      end else begin
         // Summary fields are snapshotted so they survive the next frame's accumulation.
         if (w_last) begin
            r_out_sum   <= w_sum_nxt;
            r_out_xor   <= w_xor_nxt;
            r_out_count <= w_cnt_nxt;
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_len_q     <= w_len_cfg;
                  r_state     <= w_last ? HOLD : ACCUM;
                  r_out_valid <= w_last;
               end
            end
            ACCUM: begin
               if (w_last) begin
                  r_state     <= HOLD;
                  r_out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (io.out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign io.in_ready  = w_in_ready;
   assign io.out_valid = r_out_valid;
   assign io.out_sum   = r_out_sum;
   assign io.out_xor   = r_out_xor;
   assign io.out_count = r_out_count;
   assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_valout_frame_checker.sv
// Bench for valout_frame_checker: frame-level reference model compared every cycle, plus hand-computed frame results.
module tb_valout_frame_checker;
   import valout_chk_pkg::*;

   logic                 clock;
   logic                 reset;
   logic [DEF_LEN_W-1:0] cfg_len;
   logic                 abort;
   logic                 busy;

   int checks   = 0;
   int failures = 0;

   valout_frame_checker_if vif ();

   valout_frame_checker dut (
      .clock   (clock),
      .reset   (reset),
      .cfg_len (cfg_len),
      .abort   (abort),
      .busy    (busy),
      .io      (vif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a frame is the list of accepted samples; its summary is computed once the list is full.
   logic [DEF_DATA_W-1:0] m_q[$];
   int                    m_len  = 0;
   bit                    m_hold = 1'b0;
   summary_t              m_last = '0;

   task automatic close_frame();
      longint unsigned       tot;
      logic [DEF_DATA_W-1:0] x;
      tot = 0;
      x   = '0;
      foreach (m_q[i]) begin
         tot += 64'(m_q[i]);
         x   ^= m_q[i];
      end
      m_last.sum     = tot[DEF_ACC_W-1:0];
      m_last.xor_sig = x;
      m_last.count   = (DEF_LEN_W+1)'(m_q.size());
`ifdef VALOUT_FRAME_CHECKER_OVF_EN
      m_last.ovf     = (tot >> DEF_ACC_W) != 0;
`else
      m_last.ovf     = 1'b0;
`endif
      m_q.delete();
      m_hold = 1'b1;
   endtask

   initial forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
         m_q.delete();
         m_hold = 1'b0;
         m_last = '0;
      end else if (abort) begin
         m_q.delete();
         m_hold = 1'b0;
      end else if (m_hold) begin
         if (vif.out_ready) m_hold = 1'b0;
      end else if (vif.in_valid) begin
         if (m_q.size() == 0) m_len = (cfg_len == 0) ? 256 : int'(cfg_len);
         m_q.push_back(vif.in_data);
         if (m_q.size() == m_len) close_frame();
      end
   end

   initial forever begin
      @(negedge clock);
      chk("in_ready",  64'(vif.in_ready),  64'(!m_hold && !abort));
      chk("out_valid", 64'(vif.out_valid), 64'(m_hold));
      chk("busy",      64'(busy),          64'(m_hold || (m_q.size() != 0)));
      chk("out_sum",   64'(vif.out_sum),   64'(m_last.sum));
      chk("out_xor",   64'(vif.out_xor),   64'(m_last.xor_sig));
      chk("out_count", 64'(vif.out_count), 64'(m_last.count));
      chk("out_ovf",   64'(vif.out_ovf),   64'(m_last.ovf));
   end

   task automatic send(input logic [DEF_DATA_W-1:0] d);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      vif.in_valid = 1'b1;
      vif.in_data  = d;
      while (!acc && n < 20) begin
         @(negedge clock);
         acc = vif.in_ready;
         @(posedge clock);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
      vif.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!vif.out_valid && n < 20) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (!vif.out_valid) chk("drain_timeout", 64'd0, 64'd1);
      vif.out_ready = 1'b1;
      @(posedge clock);
      #1;
      vif.out_ready = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      abort         = 1'b0;
      cfg_len       = '0;
      vif.in_valid  = 1'b0;
      vif.in_data   = '0;
      vif.out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", 64'(vif.out_valid), 64'd0);
      chk("rst_in_ready",  64'(vif.in_ready),  64'd1);
      chk("rst_out_sum",   64'(vif.out_sum),   64'd0);
      chk("rst_busy",      64'(busy),          64'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Basic three-sample frame, summary the cycle after the last sample.
      cfg_len = 8'd3;
      send(33'h1_0000_0001);
      send(33'h0_0000_0002);
      send(33'h0_FFFF_FFFF);
      chk("basic_valid", 64'(vif.out_valid), 64'd1);
      chk("basic_sum",   64'(vif.out_sum),   64'h02_0000_0002);
      chk("basic_xor",   64'(vif.out_xor),   64'h1_FFFF_FFFC);
      chk("basic_count", 64'(vif.out_count), 64'd3);

      // Backpressure: summary held, no samples taken.
      repeat (5) begin
         @(posedge clock);
         #1;
         chk("bp_in_ready", 64'(vif.in_ready),  64'd0);
         chk("bp_valid",    64'(vif.out_valid), 64'd1);
         chk("bp_sum",      64'(vif.out_sum),   64'h02_0000_0002);
      end
      vif.out_ready = 1'b1;
      @(posedge clock);
      #1;
      vif.out_ready = 1'b0;
      chk("hs_valid_drop", 64'(vif.out_valid), 64'd0);
      chk("hs_in_ready",   64'(vif.in_ready),  64'd1);
      chk("hs_sum_held",   64'(vif.out_sum),   64'h02_0000_0002);

      // Single-sample frame.
      cfg_len = 8'd1;
      send(33'h1_2345_6789);
      chk("len1_valid", 64'(vif.out_valid), 64'd1);
      chk("len1_sum",   64'(vif.out_sum),   64'h01_2345_6789);
      chk("len1_count", 64'(vif.out_count), 64'd1);
      drain();

      // cfg_len of zero means a 256-sample frame.
      cfg_len = 8'd0;
      for (int i = 0; i < 256; i++) send(33'h1);
      chk("len256_sum",   64'(vif.out_sum),   64'h100);
      chk("len256_xor",   64'(vif.out_xor),   64'h0);
      chk("len256_count", 64'(vif.out_count), 64'd256);
      drain();

      // Large samples wrap the 40-bit sum.
      for (int i = 0; i < 256; i++) send(33'h1_FFFF_FFFF);
      chk("wrap_sum", 64'(vif.out_sum), 64'hFF_FFFF_FF00);
`ifdef VALOUT_FRAME_CHECKER_OVF_EN
      chk("wrap_ovf", 64'(vif.out_ovf), 64'd1);
`else
      chk("wrap_ovf", 64'(vif.out_ovf), 64'd0);
`endif
      drain();

      // Length change mid-frame is ignored.
      cfg_len = 8'd4;
      send(33'h10);
      cfg_len = 8'd2;
      send(33'h20);
      chk("cfgchg_not_done", 64'(vif.out_valid), 64'd0);
      send(33'h30);
      send(33'h40);
      chk("cfgchg_valid", 64'(vif.out_valid), 64'd1);
      chk("cfgchg_count", 64'(vif.out_count), 64'd4);
      chk("cfgchg_sum",   64'(vif.out_sum),   64'hA0);
      drain();

      // Abort after two samples; the sample offered with abort is refused.
      cfg_len = 8'd3;
      send(33'h1_0000_0000);
      send(33'h5);
      abort        = 1'b1;
      vif.in_valid = 1'b1;
      vif.in_data  = 33'h7;
      @(negedge clock);
      chk("abort_in_ready", 64'(vif.in_ready), 64'd0);
      @(posedge clock);
      #1;
      abort        = 1'b0;
      vif.in_valid = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      cfg_len = 8'd2;
      send(33'h3);
      send(33'h5);
      chk("post_abort_sum",   64'(vif.out_sum),   64'h8);
      chk("post_abort_xor",   64'(vif.out_xor),   64'h6);
      chk("post_abort_count", 64'(vif.out_count), 64'd2);
      drain();

      // Asynchronous reset between edges in the middle of a frame.
      cfg_len = 8'd4;
      send(33'h11);
      send(33'h22);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_sum",   64'(vif.out_sum),   64'd0);
      chk("arst_xor",   64'(vif.out_xor),   64'd0);
      chk("arst_count", 64'(vif.out_count), 64'd0);
      chk("arst_busy",  64'(busy),          64'd0);
      chk("arst_valid", 64'(vif.out_valid), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (6) begin
         @(posedge clock);
         #1;
         chk("arst_no_summary", 64'(vif.out_valid), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/valout_frame_checker.md
Name: valout_frame_checker

Overview:
- Downstream consumer of the blackbox caller stage's 33-bit `io_valOut` result stream.
- Collects results into frames of `cfg_len` samples over a valid/ready handshake.
- Per frame, computes a wrap-around sum, a running XOR signature and a sample count.
- Presents the frame summary on an output valid/ready port; used as a self-check / signature point behind the blackbox datapath.

Parameters:
- DATA_W, 33, width of each incoming result sample
- ACC_W, 40, width of the frame sum accumulator (sum is modulo 2^ACC_W)
- LEN_W, 8, width of the frame-length configuration

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cfg_len  input  LEN_W  samples per frame; sampled on the first accepted sample of a frame; 0 means 2^LEN_W
- abort  input  1  synchronous frame discard
- in_valid  input  1  sample valid
- in_ready  output  1  sample accepted when in_valid && in_ready
- in_data  input  DATA_W  result sample (`io_valOut`)
- out_valid  output  1  frame summary valid
- out_ready  input  1  summary consumed when out_valid && out_ready
- out_sum  output  ACC_W  zero-extended sum of the frame's samples, mod 2^ACC_W
- out_xor  output  DATA_W  XOR of the frame's samples
- out_count  output  LEN_W+1  samples in the frame (1..2^LEN_W)
- out_ovf  output  1  sum wrapped during the frame (optional feature)
- busy  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - state=IDLE; in_ready=1; out_valid=0
  - out_sum=0, out_xor=0, out_count=0, out_ovf=0, busy=0
- State IDLE (in_ready=1):
  - On accept: sum=zext(in_data), xor=in_data, cnt=1, len_q=(cfg_len==0 ? 2^LEN_W : cfg_len).
  - If len_q==1, go to HOLD; otherwise go to ACCUM.
- State ACCUM (in_ready=1):
  - On accept: sum+=zext(in_data) mod 2^ACC_W, xor^=in_data, cnt+=1.
  - When the new cnt==len_q, go to HOLD.
- State HOLD (in_ready=0, out_valid=1):
  - Outputs are registered and stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises exactly one cycle after the cycle that accepts the frame's last sample.
- Throughput:
  - No bubble between samples within a frame.
  - One mandatory IDLE cycle after each handshake before the next frame starts.
  - in_ready is never combinationally dependent on out_ready.
- cfg_len changes mid-frame are ignored; len_q holds the value latched at the first sample.
- abort (priority over all else, any state):
  - Next state IDLE; sum/xor/cnt cleared; out_valid=0.
  - A sample presented in the abort cycle is not accepted (in_ready forced 0 that cycle).
- Output fields hold their last frame's values after the handshake until the next frame completes.
- Reset mid-frame: the partial frame is lost, and no summary is emitted.
- Widths: in_data is zero-extended to ACC_W before addition; no sign interpretation.

Optional Feature:
- Macro: VALOUT_FRAME_CHECKER_OVF_EN
- Defined:
  - A sticky flag sets when any addition in the frame carries out of bit ACC_W-1.
  - The flag is cleared on the first sample of each frame and on abort/reset.
  - Presented on out_ovf together with out_valid.
- Undefined: out_ovf is tied to 0 and no carry logic is built. The port list is unchanged.

Decomposition:
- Shared package valout_chk_pkg:
  - state enum {IDLE, ACCUM, HOLD}
  - default constants DATA_W=33, ACC_W=40, LEN_W=8
  - summary struct type {sum, xor, count, ovf}
- One sub-module, valout_frame_accum:
  - Owns the sum/xor/count/ovf registers.
  - Controls: clear, load-first, accumulate.
- The top level holds the FSM, len_q and the handshakes.

Test Plan:
- Basic frame: cfg_len=3, samples 0x1_0000_0001, 0x0_0000_0002, 0x0_FFFF_FFFF back-to-back → one cycle after the 3rd sample, out_valid=1 with out_sum=0x02_0000_0002, out_xor=0x1_FFFF_FFFC, out_count=3.
- Backpressure: hold out_ready=0 for 5 cycles → in_ready=0 throughout, outputs stable. Assert out_ready → IDLE and in_ready=1 on the next cycle.
- Edge lengths:
  - cfg_len=1 with sample 0x1_2345_6789 → out_valid the next cycle, out_sum=0x01_2345_6789, out_count=1.
  - cfg_len=0 with 256 samples of 0x1 → out_sum=0x100, out_xor=0, out_count=256.
- Abort/config change: change cfg_len from 4 to 2 after the 1st sample → frame still closes at 4 samples. Abort after 2 samples, then a fresh 2-sample frame → its summary excludes the aborted data.
- Reset and overflow:
  - Assert async reset mid-ACCUM and between clock edges → all outputs 0 immediately, no summary emitted.
  - With VALOUT_FRAME_CHECKER_OVF_EN and ACC_W=33: two samples of 0x1_8000_0000 → out_ovf=1, out_sum=0x1_0000_0000.
